// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the multiplexed BCD display scan controller.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/bcd_decoder.sv
// BCD to active-low 7-segment decoder; segments a..g on bits [6]..[0].
// Codes above 9 decode to an all-off pattern.
module bcd_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= BCD_MAX) begin
      case (bcd)
        4'd0:    seg = 7'b0000001;
        4'd1:    seg = 7'b1001111;
        4'd2:    seg = 7'b0010010;
        4'd3:    seg = 7'b0000110;
        4'd4:    seg = 7'b1001100;
        4'd5:    seg = 7'b0100100;
        4'd6:    seg = 7'b0100000;
        4'd7:    seg = 7'b0001111;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0000100;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a frame-synchronous
// double-buffered load port. Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state, state_next;
  logic [SLOT_W-1:0]       slot_cnt, slot_next;
  logic [IDX_W-1:0]        digit_idx, idx_next;
  logic                    frame_boundary, xfer, commit;
  logic [4*NUM_DIGITS-1:0] active_bcd, pend_bcd;
  logic [NUM_DIGITS-1:0]   active_dp, pend_dp;
  logic                    pend_vld;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              dec_seg, show_seg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_next;
      slot_cnt  <= slot_next;
      digit_idx <= idx_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next     = state;
    slot_next      = slot_cnt;
    idx_next       = digit_idx;
    frame_boundary = enable && (state == ST_SHOW) && (slot_cnt == SLOT_LAST)
                     && (digit_idx == IDX_LAST);
    if (!enable) begin
      state_next = ST_IDLE;
      slot_next  = '0;
      idx_next   = '0;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_BLANK;
        ST_BLANK: begin
          slot_next = slot_cnt + SLOT_W'(1);
          if (slot_cnt == BLANK_LAST) state_next = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_next  = '0;
            state_next = ST_BLANK;
            idx_next   = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
          end else begin
            slot_next = slot_cnt + SLOT_W'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Digit mux feeding the single shared decoder.
  always_comb begin
    cur_bcd = '0;
    cur_dp  = 1'b0;
    an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_bcd   = active_bcd[4*i +: 4];
        cur_dp    = active_dp[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  bcd_decoder u_decoder (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

`ifdef BCD_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
  always_comb begin : lzb_comb
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (active_bcd[4*i +: 4] == 4'd0);
      lz_blank[i] = upper_zero;
    end
  end

  assign show_seg = (|(lz_blank & ~an_sel)) ? SEG_BLANK : dec_seg;
`else
  assign show_seg = dec_seg;
`endif

  // Anode, segments and dp come from one register stage so they can never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_out     <= '1;
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_boundary;
      if (enable && state == ST_SHOW) begin
        an_out  <= an_sel;
        seg_out <= show_seg;
        dp_out  <= ~cur_dp;
      end else begin
        an_out  <= '1;
        seg_out <= SEG_BLANK;
        dp_out  <= 1'b1;
      end
    end
  end

  assign xfer   = load_valid && load_ready;
  assign commit = pend_vld && (frame_boundary || state == ST_IDLE);

  // load_ready is kept as the registered complement of pend_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bcd <= '0;
      active_dp  <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      load_ready <= 1'b1;
    end else if (xfer) begin
      pend_bcd   <= load_data;
      pend_dp    <= load_dp;
      pend_vld   <= 1'b1;
      load_ready <= 1'b0;
    end else if (commit) begin
      active_bcd <= pend_bcd;
      active_dp  <= pend_dp;
      pend_vld   <= 1'b0;
      load_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed scenarios then random traffic,
// compared every cycle against a phase-counting model of the display.
module tb_bcd_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst, enable, load_valid;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_ready;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out, frame_tick;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_ready (load_ready),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  int errors = 0;
  int checks = 0;

  // Model: run = cycles elapsed since the scan left idle, -1 while idle.
  int          run;
  logic [15:0] m_active, m_pend;
  logic [3:0]  m_active_dp, m_pend_dp;
  bit          m_pend_vld, last_xfer;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    run         = -1;
    m_active    = '0;
    m_active_dp = '0;
    m_pend      = '0;
    m_pend_dp   = '0;
    m_pend_vld  = 0;
    last_xfer   = 0;
  endtask

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    int  slot, dig;
    bit  boundary, commit;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    boundary = 0;
    if (run >= 0 && enable) begin
      slot = run % RD;
      dig  = (run / RD) % N;
      if (slot >= BC) begin
        e_an  = ~(4'b0001 << dig);
        e_seg = seg_of(m_active[4*dig +: 4]);
`ifdef BCD_SCAN_LZB_EN
        if (dig > 0 && (m_active >> (4*dig)) == 16'd0) e_seg = 7'h7F;
`endif
        e_dp = ~m_active_dp[dig];
      end
      boundary = (run % FRAME) == FRAME - 1;
      e_tick   = boundary;
    end
    last_xfer = load_valid && !m_pend_vld;
    commit    = m_pend_vld && (run < 0 || boundary);
    if (last_xfer) begin
      m_pend = load_data; m_pend_dp = load_dp; m_pend_vld = 1;
    end else if (commit) begin
      m_active = m_pend; m_active_dp = m_pend_dp; m_pend_vld = 0;
    end
    if (!enable)     run = -1;
    else if (run < 0) run = 0;
    else             run++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("an",    32'(an_out),     32'(e_an));
    check("seg",   32'(seg_out),    32'(e_seg));
    check("dp",    32'(dp_out),     32'(e_dp));
    check("tick",  32'(frame_tick), 32'(e_tick));
    check("ready", 32'(load_ready), 32'(!m_pend_vld));
  endtask

  task automatic post(input logic [15:0] d, input logic [3:0] p);
    int n;
    load_valid = 1'b1; load_data = d; load_dp = p;
    n = 0; last_xfer = 0;
    while (!last_xfer && n < 64) begin cycle(); n++; end
    check("xfer_done", 32'(last_xfer), 1);
    load_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    while (an_out !== target && n < 64) begin cycle(); n++; end
    check("an_wait", 32'(an_out), 32'(target));
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin cycle(); n++; end
    check("tick_wait", 32'(frame_tick), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0; load_dp = '0;
    model_reset();
    #3;
    check("rst_an",    32'(an_out),     'hF);
    check("rst_seg",   32'(seg_out),    'h7F);
    check("rst_dp",    32'(dp_out),     1);
    check("rst_tick",  32'(frame_tick), 0);
    check("rst_ready", 32'(load_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with enable low: dark and ready.
    repeat (6) cycle();

    // Scan order with 1234.
    post(16'h1234, 4'b0000);
    cycle();
    enable = 1'b1;
    wait_an(4'hE); check("d0_4", 32'(seg_out), 32'b1001100); check("d0_dp", 32'(dp_out), 1);
    wait_an(4'hD); check("d1_3", 32'(seg_out), 32'b0000110);
    wait_an(4'hB); check("d2_2", 32'(seg_out), 32'b0010010);
    wait_an(4'h7); check("d3_1", 32'(seg_out), 32'b1001111);
    wait_tick();
    n = 0;
    do begin cycle(); n++; end while (frame_tick !== 1'b1 && n < 100);
    check("tick_period", n, 32);

    // Tear-free update: posted mid-frame, shown after the boundary.
    wait_an(4'hD);
    post(16'h5678, 4'b0000);
    check("ready_low", 32'(load_ready), 0);
    wait_an(4'hB); check("keep_old", 32'(seg_out), 32'b0010010);
    wait_tick();
    wait_an(4'hE); check("new_8", 32'(seg_out), 32'b0000000);

    // Invalid digit with decimal point.
    post(16'h9A00, 4'b0100);
    wait_tick();
    wait_an(4'hB); check("inv_seg", 32'(seg_out), 'h7F); check("inv_dp", 32'(dp_out), 0);
    wait_an(4'h7); check("d3_9", 32'(seg_out), 32'b0000100); check("d3_dp", 32'(dp_out), 1);

    // Leading-zero cases.
    post(16'h0070, 4'b0000);
    wait_tick();
    wait_an(4'hD); check("lz_7", 32'(seg_out), 32'b0001111);
`ifdef BCD_SCAN_LZB_EN
    wait_an(4'hB); check("lz_d2", 32'(seg_out), 'h7F);
`else
    wait_an(4'hB); check("lz_d2", 32'(seg_out), 32'b0000001);
`endif
    wait_an(4'hE); check("lz_d0", 32'(seg_out), 32'b0000001);
    post(16'h0000, 4'b0000);
    wait_tick();
`ifdef BCD_SCAN_LZB_EN
    wait_an(4'h7); check("z_d3", 32'(seg_out), 'h7F);
`else
    wait_an(4'h7); check("z_d3", 32'(seg_out), 32'b0000001);
`endif
    wait_an(4'hE); check("z_d0", 32'(seg_out), 32'b0000001);

    // Disable mid-SHOW, then re-enable from digit 0 after three dark cycles.
    wait_an(4'hD);
    cycle();
    enable = 1'b0;
    cycle(); check("dis_dark", 32'(an_out), 'hF);
    repeat (3) cycle();
    enable = 1'b1;
    repeat (3) cycle();
    check("reen_dark", 32'(an_out), 'hF);
    cycle(); check("reen_d0", 32'(an_out), 'hE);

    // Asynchronous reset mid-SHOW discards a pending value.
    post(16'h4321, 4'hF);
    wait_an(4'hD);
    #2 rst = 1'b1;
    #1;
    check("arst_an",    32'(an_out),     'hF);
    check("arst_seg",   32'(seg_out),    'h7F);
    check("arst_dp",    32'(dp_out),     1);
    check("arst_ready", 32'(load_ready), 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_an(4'hE); check("arst_d0", 32'(seg_out), 32'b0000001); check("arst_dp0", 32'(dp_out), 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!load_valid && $urandom_range(0, 15) == 0) begin
        load_valid = 1'b1;
        load_data  = 16'($urandom);
        load_dp    = 4'($urandom);
      end
      if ($urandom_range(0, 199) == 0) enable = !enable;
      cycle();
      if (last_xfer) load_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
